// File: rtl/page_rank_if.sv
// rtl/page_rank_if.sv - graph input and rank output bundle for page_rank
// The host drives the graph and reads node 0's rank through this bundle.
interface page_rank_if #(
  parameter int N     = 64,
  parameter int WIDTH = 16
);
  logic [N*N-1:0]     adj;
  logic [N*WIDTH-1:0] nodeWeight;
  logic [WIDTH-1:0]   node0Val;

  modport master (output adj, output nodeWeight, input node0Val);
  modport slave  (input adj, input nodeWeight, output node0Val);
endinterface

// File: rtl/page_rank.sv
// rtl/page_rank.sv - fixed-point damped PageRank engine exposing node 0's rank
// Each iteration processes one column per cycle, then updates all ranks at once.
module page_rank #(
  parameter int               N     = 64,
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] DAMP  = 16'hD99A,
  parameter int               ITERS = 16
) (
  input  logic          clk,
  input  logic          reset,
  page_rank_if.slave    pr_if
);
  localparam int LOGN = $clog2(N);
  localparam int AW   = WIDTH + LOGN;
  localparam int DW   = AW + WIDTH;
  localparam int IW   = $clog2(ITERS + 1);

  localparam logic [WIDTH-1:0] INIT = WIDTH'((longint'(1) << WIDTH) / N);
  localparam logic [WIDTH-1:0] BASE = WIDTH'(((longint'(1) << WIDTH) - longint'(DAMP)) / N);
  localparam logic [AW:0]      MAXV = (AW+1)'((longint'(1) << WIDTH) - 1);

  typedef enum logic [1:0] {S_RUN, S_UPDATE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LOGN-1:0]  col_q, col_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [WIDTH-1:0] node0_q, node0_d;
  logic [WIDTH-1:0] val_q [N];
  logic [WIDTH-1:0] val_d [N];
  logic [AW-1:0]    acc_q [N];
  logic [AW-1:0]    acc_d [N];

  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] cur_wt;
  logic [WIDTH-1:0] p;
  logic [AW-1:0]    scaled [N];
  logic [AW:0]      upd_sum [N];
  logic [WIDTH-1:0] upd_val [N];

  // Contribution of the current column: truncated Q0.WIDTH product.
  always_comb begin
    cur_val = val_q[col_q];
    cur_wt  = pr_if.nodeWeight[int'(col_q)*WIDTH +: WIDTH];
    p       = WIDTH'(({{WIDTH{1'b0}}, cur_val} * {{WIDTH{1'b0}}, cur_wt}) >> WIDTH);
  end

  // Damped, biased and saturated candidate rank for every node.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      scaled[i]  = AW'((DW'(DAMP) * DW'(acc_q[i])) >> WIDTH);
      upd_sum[i] = (AW+1)'(BASE) + {1'b0, scaled[i]};
      if (upd_sum[i] > MAXV) begin
        upd_val[i] = '1;
      end else begin
        upd_val[i] = upd_sum[i][WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    iter_d  = iter_q;
    node0_d = node0_q;
    val_d   = val_q;
    acc_d   = acc_q;
    case (state_q)
      S_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (pr_if.adj[i*N + int'(col_q)]) begin
            acc_d[i] = acc_q[i] + AW'(p);
          end
        end
        col_d = col_q + 1'b1;
        if (col_q == LOGN'(N - 1)) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        for (int i = 0; i < N; i++) begin
          val_d[i] = upd_val[i];
          acc_d[i] = '0;
        end
        node0_d = upd_val[0];
        col_d   = '0;
        iter_d  = iter_q + 1'b1;
        state_d = (iter_q == IW'(ITERS - 1)) ? S_DONE : S_RUN;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      col_q   <= '0;
      iter_q  <= '0;
      node0_q <= INIT;
      for (int i = 0; i < N; i++) begin
        val_q[i] <= INIT;
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      iter_q  <= iter_d;
      node0_q <= node0_d;
      for (int i = 0; i < N; i++) begin
        val_q[i] <= val_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign pr_if.node0Val = node0_q;

endmodule

// File: tb/tb_page_rank.sv
// tb/tb_page_rank.sv - directed self-checking bench for page_rank
// Edge k counts rising edges after reset release; outputs are sampled 1ns after each edge.
module tb_page_rank;
  localparam int N     = 64;
  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  page_rank_if #(.N(N), .WIDTH(WIDTH)) pr_if ();

  page_rank #(.N(N), .WIDTH(WIDTH), .DAMP(16'hD99A), .ITERS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .pr_if (pr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      edges(1);
      check("reset_val", pr_if.node0Val, 16'd1024);
    end
    reset = 1'b0;
  endtask

  task automatic hold_check(input string tag, input int n, input logic [WIDTH-1:0] exp);
    for (int k = 0; k < n; k++) begin
      edges(1);
      check(tag, pr_if.node0Val, exp);
    end
  endtask

  function automatic int model_next(input int v, input int w);
    int p;
    int s;
    p = int'((longint'(v) * longint'(w)) >>> 16);
    s = 153 + int'((longint'(55706) * longint'(p)) >>> 16);
    return (s > 65535) ? 65535 : s;
  endfunction

  int v;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    pr_if.adj        = '0;
    pr_if.nodeWeight = '0;

    // Reset value and empty graph
    apply_reset(2);
    hold_check("post_reset_hold", 64, 16'd1024);
    edges(1);
    check("empty_iter1", pr_if.node0Val, 16'd153);
    for (int it = 2; it <= 16; it++) begin
      edges(65);
      check("empty_iterN", pr_if.node0Val, 16'd153);
    end
    hold_check("empty_done", 70, 16'd153);

    // Single in-edge from node 1 with weight 1/2
    pr_if.adj = '0;
    pr_if.adj[1] = 1'b1;
    pr_if.nodeWeight = '0;
    pr_if.nodeWeight[1*WIDTH +: WIDTH] = 16'h8000;
    apply_reset(1);
    edges(64);
    check("single_before_upd", pr_if.node0Val, 16'd1024);
    edges(1);
    check("single_iter1", pr_if.node0Val, 16'd588);
    edges(64);
    check("single_hold1", pr_if.node0Val, 16'd588);
    edges(1);
    check("single_iter2", pr_if.node0Val, 16'd217);
    edges(1040 - 130);
    check("single_edge1040", pr_if.node0Val, 16'd217);
    hold_check("single_done", 100, 16'd217);

    // Mid-run reset pulse at edge 100
    apply_reset(1);
    edges(65);
    check("midrst_iter1", pr_if.node0Val, 16'd588);
    edges(34);
    reset = 1'b1;
    edges(1);
    check("midrst_edge100", pr_if.node0Val, 16'd1024);
    reset = 1'b0;
    hold_check("midrst_hold", 64, 16'd1024);
    edges(1);
    check("midrst_restart", pr_if.node0Val, 16'd588);

    // Self-loop on node 0 with weight ~1, compared to a bit-accurate model
    pr_if.adj = '0;
    pr_if.adj[0] = 1'b1;
    pr_if.nodeWeight = '0;
    pr_if.nodeWeight[0 +: WIDTH] = 16'hFFFF;
    apply_reset(1);
    v = 1024;
    for (int it = 1; it <= 16; it++) begin
      edges(64);
      check("self_pre_upd", pr_if.node0Val, WIDTH'(v));
      v = model_next(v, 65535);
      edges(1);
      check("self_iter", pr_if.node0Val, WIDTH'(v));
    end
    check("self_iter1_const", WIDTH'(model_next(1024, 65535)), 16'd1022);
    hold_check("self_done", 130, WIDTH'(v));

    // Fan-in from nodes 1..63, all weights ~1
    pr_if.adj = '0;
    for (int j = 1; j < N; j++) pr_if.adj[j] = 1'b1;
    pr_if.nodeWeight = '1;
    apply_reset(1);
    edges(64);
    check("fanin_pre_upd", pr_if.node0Val, 16'd1024);
    edges(1);
    check("fanin_iter1", pr_if.node0Val, 16'd54935);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
